// File: rtl/cheri_encoder_if.sv
// Request and encoded-instruction streams of the CHERI instruction encoder.
// The encoder uses the slave modport; the request source/instruction sink uses master.
interface cheri_encoder_if #(
    parameter int OPDW = 32
);
    logic            req_valid_i;
    logic            req_ready_o;
    logic [OPDW-1:0] cheri_operator_i;
    logic [4:0]      rd_i;
    logic [4:0]      rs1_i;
    logic [4:0]      rs2_i;
    logic [31:0]     imm_i;
    logic            instr_valid_o;
    logic            instr_ready_i;
    logic [31:0]     instr_o;
    logic            instr_last_o;
    logic            instr_err_o;

    modport slave (
        input  req_valid_i, cheri_operator_i, rd_i, rs1_i, rs2_i, imm_i, instr_ready_i,
        output req_ready_o, instr_valid_o, instr_o, instr_last_o, instr_err_o
    );

    modport master (
        output req_valid_i, cheri_operator_i, rd_i, rs1_i, rs2_i, imm_i, instr_ready_i,
        input  req_ready_o, instr_valid_o, instr_o, instr_last_o, instr_err_o
    );
endinterface

// File: rtl/cheri_encoder.sv
// CHERIoT instruction encoder: one-hot operator plus operands in, 32-bit instruction words out.
// Out-of-range CJAL may be expanded into an AUIPCC + CJALR pair.
module cheri_encoder #(
    parameter bit ExpandFarJal = 1'b1
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    cheri_encoder_if.slave bus
);
    localparam int OPDW = 32;

    localparam logic [4:0] OP_CINC_ADDR_IMM   = 5'd22;
    localparam logic [4:0] OP_CSET_BOUNDS_IMM = 5'd23;
    localparam logic [4:0] OP_CJALR           = 5'd24;
    localparam logic [4:0] OP_CLOAD_CAP       = 5'd25;
    localparam logic [4:0] OP_CSTORE_CAP      = 5'd26;
    localparam logic [4:0] OP_CAUIPCC         = 5'd27;
    localparam logic [4:0] OP_CAUICGP         = 5'd28;
    localparam logic [4:0] OP_CJAL            = 5'd29;

    localparam logic [6:0] OPC_CHERI  = 7'h5b;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_AUICGP = 7'h7b;
    localparam logic [6:0] OPC_JAL    = 7'h6f;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SECOND = 1'b1
    } state_e;

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [4:0] rd);
        return {f7, rs2, rs1, 3'b000, rd, OPC_CHERI};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm12, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] opc);
        return {imm12, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm12, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        return {imm12[11:5], rs2, rs1, 3'b011, imm12[4:0], OPC_STORE};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] imm20, input logic [4:0] rd,
                                          input logic [6:0] opc);
        return {imm20, rd, opc};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:1] off, input logic [4:0] rd);
        return {off[20], off[10:1], off[11], off[19:12], rd, OPC_JAL};
    endfunction

    // Value fits a signed 12-bit field when bits [31:11] are a pure sign extension.
    function automatic logic fits_s12(input logic [20:0] hi);
        return (hi == 21'h000000) || (hi == 21'h1fffff);
    endfunction

    function automatic logic [6:0] r_func7(input logic [4:0] idx);
        case (idx)
            5'd0:    return 7'h01;
            5'd1:    return 7'h08;
            5'd2:    return 7'h09;
            5'd3:    return 7'h0b;
            5'd4:    return 7'h0c;
            5'd5:    return 7'h0d;
            5'd6:    return 7'h10;
            5'd7:    return 7'h11;
            5'd8:    return 7'h14;
            5'd9:    return 7'h20;
            5'd10:   return 7'h21;
            default: return 7'h00;
        endcase
    endfunction

    function automatic logic [4:0] unary_sub(input logic [4:0] idx);
        case (idx)
            5'd11:   return 5'h00;
            5'd12:   return 5'h01;
            5'd13:   return 5'h02;
            5'd14:   return 5'h03;
            5'd15:   return 5'h04;
            5'd16:   return 5'h08;
            5'd17:   return 5'h09;
            5'd18:   return 5'h0a;
            5'd19:   return 5'h0b;
            5'd20:   return 5'h0f;
            5'd21:   return 5'h18;
            default: return 5'h00;
        endcase
    endfunction

    state_e      r_state;
    logic        r_valid;
    logic [31:0] r_instr;
    logic        r_last;
    logic        r_err;
    logic [31:0] r_beat2;

    logic [5:0]  w_op_cnt;
    logic [4:0]  w_op_idx;
    logic        w_ok;
    logic        w_two;
    logic [31:0] w_word1;
    logic [31:0] w_word2;
    logic [19:0] w_hi20;
    logic        w_jal_near;
    logic        w_s12;
    logic        w_req_ready;
    logic        w_accept;
    logic        w_consume;

    assign w_req_ready = (r_state == ST_IDLE) & (~r_valid | bus.instr_ready_i);
    assign w_accept    = bus.req_valid_i & w_req_ready;
    assign w_consume   = r_valid & bus.instr_ready_i;

    // (imm + 0x800) >> 12 without a full adder: the rounding carry is imm[11].
    assign w_hi20     = bus.imm_i[31:12] + {19'd0, bus.imm_i[11]};
    assign w_jal_near = (bus.imm_i[31:20] == 12'h000) || (bus.imm_i[31:20] == 12'hfff);
    assign w_s12      = fits_s12(bus.imm_i[31:11]);

    // Count set operator bits and recover the index of the (assumed single) set bit.
    always_comb begin
        w_op_cnt = 6'd0;
        w_op_idx = 5'd0;
        for (int i = 0; i < OPDW; i++) begin
            w_op_cnt = w_op_cnt + {5'd0, bus.cheri_operator_i[i]};
            w_op_idx = w_op_idx | (bus.cheri_operator_i[i] ? 5'(i) : 5'd0);
        end
    end

    // Encode the request and judge its legality; w_ok=0 means an error beat.
    always_comb begin
        w_ok    = 1'b0;
        w_two   = 1'b0;
        w_word1 = 32'h0000_0000;
        w_word2 = 32'h0000_0000;
        if (w_op_cnt == 6'd1) begin
            case (w_op_idx) inside
                [5'd0:5'd10]: begin
                    w_ok    = 1'b1;
                    w_word1 = enc_r(r_func7(w_op_idx), bus.rs2_i, bus.rs1_i, bus.rd_i);
                end
                [5'd11:5'd21]: begin
                    w_ok    = 1'b1;
                    w_word1 = enc_r(7'h7f, unary_sub(w_op_idx), bus.rs1_i, bus.rd_i);
                end
                OP_CINC_ADDR_IMM: begin
                    w_ok    = w_s12;
                    w_word1 = enc_i(bus.imm_i[11:0], bus.rs1_i, 3'd1, bus.rd_i, OPC_CHERI);
                end
                OP_CSET_BOUNDS_IMM: begin
                    w_ok    = (bus.imm_i[31:12] == 20'h00000);
                    w_word1 = enc_i(bus.imm_i[11:0], bus.rs1_i, 3'd2, bus.rd_i, OPC_CHERI);
                end
                OP_CJALR: begin
                    w_ok    = w_s12;
                    w_word1 = enc_i(bus.imm_i[11:0], bus.rs1_i, 3'd0, bus.rd_i, OPC_JALR);
                end
                OP_CLOAD_CAP: begin
                    w_ok    = w_s12;
                    w_word1 = enc_i(bus.imm_i[11:0], bus.rs1_i, 3'd3, bus.rd_i, OPC_LOAD);
                end
                OP_CSTORE_CAP: begin
                    w_ok    = w_s12;
                    w_word1 = enc_s(bus.imm_i[11:0], bus.rs2_i, bus.rs1_i);
                end
                OP_CAUIPCC, OP_CAUICGP: begin
                    w_ok    = (bus.imm_i[31:20] == 12'h000);
                    w_word1 = enc_u(bus.imm_i[19:0], bus.rd_i,
                                    (w_op_idx == OP_CAUIPCC) ? OPC_AUIPC : OPC_AUICGP);
                end
                OP_CJAL: begin
                    if (bus.imm_i[0]) begin
                        w_ok = 1'b0;
                    end else if (w_jal_near) begin
                        w_ok    = 1'b1;
                        w_word1 = enc_j(bus.imm_i[20:1], bus.rd_i);
                    end else if (ExpandFarJal && (bus.rd_i != 5'd0)) begin
                        w_ok    = 1'b1;
                        w_two   = 1'b1;
                        w_word1 = enc_u(w_hi20, bus.rd_i, OPC_AUIPC);
                        w_word2 = enc_i(bus.imm_i[11:0], bus.rd_i, 3'd0, bus.rd_i, OPC_JALR);
                    end else begin
                        w_ok = 1'b0;
                    end
                end
                default: w_ok = 1'b0;
            endcase
        end else begin
            w_ok = 1'b0;
        end
    end

    // Output register and expansion FSM; beat 2 waits in r_beat2 while in SECOND.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_instr <= 32'h0000_0000;
            r_last  <= 1'b0;
            r_err   <= 1'b0;
            r_beat2 <= 32'h0000_0000;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_valid <= 1'b1;
                        r_instr <= w_ok ? w_word1 : 32'h0000_0000;
                        r_last  <= ~w_two;
                        r_err   <= ~w_ok;
                        r_beat2 <= w_word2;
                        r_state <= w_two ? ST_SECOND : ST_IDLE;
                    end else if (w_consume) begin
                        r_valid <= 1'b0;
                    end else begin
                        r_valid <= r_valid;
                    end
                end
                ST_SECOND: begin
                    if (w_consume) begin
                        r_valid <= 1'b1;
                        r_instr <= r_beat2;
                        r_last  <= 1'b1;
                        r_err   <= 1'b0;
                        r_beat2 <= 32'h0000_0000;
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_SECOND;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready_o   = w_req_ready;
    assign bus.instr_valid_o = r_valid;
    assign bus.instr_o       = r_instr;
    assign bus.instr_last_o  = r_last;
    assign bus.instr_err_o   = r_err;
endmodule

// File: tb/tb_cheri_encoder.sv
// Self-checking bench for cheri_encoder: directed scenarios plus a randomized stream
// scored against a behavioural model of the encoding rules.
module tb_cheri_encoder;
    localparam int OP_CSET_BOUNDS  = 1;
    localparam int OP_CSET_ADDR    = 6;
    localparam int OP_GET_LEN      = 14;
    localparam int OP_CINC_IMM     = 22;
    localparam int OP_CSETB_IMM    = 23;
    localparam int OP_CAUIPCC      = 27;
    localparam int OP_CJAL         = 29;

    localparam logic [6:0] R7   [0:10] = '{7'h01, 7'h08, 7'h09, 7'h0b, 7'h0c, 7'h0d,
                                          7'h10, 7'h11, 7'h14, 7'h20, 7'h21};
    localparam logic [4:0] USUB [0:10] = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h08,
                                          5'h09, 5'h0a, 5'h0b, 5'h0f, 5'h18};
    localparam logic [31:0] BND [0:14] = '{32'd2047, 32'd2048, 32'hFFFFF800, 32'hFFFFF7FF,
                                           32'd4095, 32'd4096, 32'd0, 32'hFFFFFFFF,
                                           32'h000FFFFE, 32'h00100000, 32'hFFF00000,
                                           32'hFFEFFFFE, 32'h000FFFFF, 32'h00000FFF,
                                           32'h80000000};

    typedef struct {
        logic [31:0] word;
        logic        last;
        logic        err;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    cheri_encoder_if #(.OPDW(32)) bus ();
    cheri_encoder_if #(.OPDW(32)) bus_nx ();

    cheri_encoder #(.ExpandFarJal(1'b1)) u_dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));
    cheri_encoder #(.ExpandFarJal(1'b0)) u_dut_nx (.clk_i(clk), .rst_ni(rst_n), .bus(bus_nx));

    function automatic logic [31:0] op_bit(input int idx);
        logic [31:0] one = 32'h1;
        return one << idx;
    endfunction

    // Reference: encoding rules evaluated with integer arithmetic; returns the beat count.
    function automatic int model(input logic [31:0] opv, input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [31:0] imm, input bit expand,
                                 output beat_t b1, output beat_t b2);
        int          idx;
        int          s;
        bit          ok;
        logic [31:0] w;
        logic [31:0] hi;
        b1 = '{32'h0, 1'b1, 1'b1};
        b2 = '{32'h0, 1'b1, 1'b1};
        if ($countones(opv) != 1) return 1;
        idx = 0;
        for (int i = 0; i < 32; i++) if (opv[i]) idx = i;
        s  = $signed(imm);
        ok = 1'b0;
        w  = 32'h0;
        if (idx <= 10) begin
            ok = 1'b1;
            w  = (32'(R7[idx]) << 25) + (32'(rs2) << 20) + (32'(rs1) << 15) + (32'(rd) << 7) + 32'h5b;
        end else if (idx <= 21) begin
            ok = 1'b1;
            w  = (32'h7f << 25) + (32'(USUB[idx-11]) << 20) + (32'(rs1) << 15) + (32'(rd) << 7) + 32'h5b;
        end else if (idx == 22 || idx == 24 || idx == 25) begin
            ok = (s >= -2048) && (s <= 2047);
            w  = ((imm & 32'hfff) << 20) + (32'(rs1) << 15) + (32'(rd) << 7);
            w  = w + ((idx == 22) ? 32'h105b : (idx == 24) ? 32'h0067 : 32'h3003);
        end else if (idx == 23) begin
            ok = (imm <= 32'd4095);
            w  = ((imm & 32'hfff) << 20) + (32'(rs1) << 15) + 32'h2000 + (32'(rd) << 7) + 32'h5b;
        end else if (idx == 26) begin
            ok = (s >= -2048) && (s <= 2047);
            w  = (((imm >> 5) & 32'h7f) << 25) + (32'(rs2) << 20) + (32'(rs1) << 15) + 32'h3000
                 + ((imm & 32'h1f) << 7) + 32'h23;
        end else if (idx == 27 || idx == 28) begin
            ok = (imm < 32'h00100000);
            w  = (imm << 12) + (32'(rd) << 7) + ((idx == 27) ? 32'h17 : 32'h7b);
        end else if (idx == 29) begin
            if (imm[0]) begin
                ok = 1'b0;
            end else if (s >= -(1 << 20) && s <= (1 << 20) - 2) begin
                ok = 1'b1;
                w  = (((imm >> 20) & 32'h1) << 31) + (((imm >> 1) & 32'h3ff) << 21)
                     + (((imm >> 11) & 32'h1) << 20) + (((imm >> 12) & 32'hff) << 12)
                     + (32'(rd) << 7) + 32'h6f;
            end else if (expand && rd != 5'd0) begin
                hi = (imm + 32'h800) >> 12;
                b1 = '{(hi << 12) + (32'(rd) << 7) + 32'h17, 1'b0, 1'b0};
                b2 = '{((imm & 32'hfff) << 20) + (32'(rd) << 15) + (32'(rd) << 7) + 32'h67, 1'b1, 1'b0};
                return 2;
            end else begin
                ok = 1'b0;
            end
        end
        if (ok) b1 = '{w, 1'b1, 1'b0};
        return 1;
    endfunction

    task automatic set_idle();
        bus.req_valid_i = 1'b0; bus.cheri_operator_i = 32'h0; bus.rd_i = 5'd0; bus.rs1_i = 5'd0;
        bus.rs2_i = 5'd0; bus.imm_i = 32'h0; bus.instr_ready_i = 1'b1;
        bus_nx.req_valid_i = 1'b0; bus_nx.cheri_operator_i = 32'h0; bus_nx.rd_i = 5'd0;
        bus_nx.rs1_i = 5'd0; bus_nx.rs2_i = 5'd0; bus_nx.imm_i = 32'h0; bus_nx.instr_ready_i = 1'b1;
    endtask

    // Drive one cycle from a negedge; returns acceptance and ends at the next negedge.
    task automatic tick(input bit v, input logic [31:0] opv, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm, input bit rdy,
                        output bit acc, output bit acc_nx);
        bus.req_valid_i = v; bus.cheri_operator_i = opv; bus.rd_i = rd; bus.rs1_i = rs1;
        bus.rs2_i = rs2; bus.imm_i = imm; bus.instr_ready_i = rdy;
        bus_nx.req_valid_i = v; bus_nx.cheri_operator_i = opv; bus_nx.rd_i = rd; bus_nx.rs1_i = rs1;
        bus_nx.rs2_i = rs2; bus_nx.imm_i = imm; bus_nx.instr_ready_i = rdy;
        #1;
        acc    = v & bus.req_ready_o;
        acc_nx = v & bus_nx.req_ready_o;
        @(negedge clk);
        bus.req_valid_i = 1'b0; bus_nx.req_valid_i = 1'b0;
    endtask

    task automatic do_reset();
        set_idle();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        set_idle();
        rst_n = 1'b0;
        #2;
        n_checks++;
        if ({bus.instr_valid_o, bus.instr_o, bus.instr_last_o, bus.instr_err_o, bus.req_ready_o}
            !== {1'b0, 32'h0, 1'b0, 1'b0, 1'b1}) begin
            n_errors++;
            $display("FAIL reset: got v=%b w=%h l=%b e=%b rdy=%b want v=0 w=0 l=0 e=0 rdy=1",
                     bus.instr_valid_o, bus.instr_o, bus.instr_last_o, bus.instr_err_o, bus.req_ready_o);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        bit acc, accx;
        do_reset();
        tick(1'b1, op_bit(OP_CINC_IMM), 5'd5, 5'd6, 5'd0, 32'h7ff, 1'b1, acc, accx);
        n_checks++;
        if ({acc, bus.instr_valid_o, bus.instr_o, bus.instr_last_o, bus.instr_err_o}
            !== {1'b1, 1'b1, 32'h7FF312DB, 1'b1, 1'b0}) begin
            n_errors++;
            $display("FAIL cinc_imm: got acc=%b v=%b w=%h l=%b e=%b want acc=1 v=1 w=7ff312db l=1 e=0",
                     acc, bus.instr_valid_o, bus.instr_o, bus.instr_last_o, bus.instr_err_o);
        end
        tick(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b1, acc, accx);
        n_checks++;
        if (bus.instr_valid_o !== 1'b0) begin
            n_errors++;
            $display("FAIL cinc_imm_drain: got v=%b want 0", bus.instr_valid_o);
        end
    endtask

    task automatic test_back_to_back();
        bit acc, accx;
        do_reset();
        tick(1'b1, op_bit(OP_GET_LEN), 5'd1, 5'd2, 5'h1f, 32'h0, 1'b1, acc, accx);
        n_checks++;
        if ({acc, bus.instr_valid_o, bus.instr_o} !== {1'b1, 1'b1, 32'hFE3100DB}) begin
            n_errors++;
            $display("FAIL b2b_get_len: got acc=%b v=%b w=%h want acc=1 v=1 w=fe3100db",
                     acc, bus.instr_valid_o, bus.instr_o);
        end
        tick(1'b1, op_bit(OP_CSET_ADDR), 5'd1, 5'd2, 5'd3, 32'h0, 1'b1, acc, accx);
        n_checks++;
        if ({acc, bus.instr_valid_o, bus.instr_o, bus.instr_last_o} !== {1'b1, 1'b1, 32'h203100DB, 1'b1}) begin
            n_errors++;
            $display("FAIL b2b_cset_addr: got acc=%b v=%b w=%h l=%b want acc=1 v=1 w=203100db l=1",
                     acc, bus.instr_valid_o, bus.instr_o, bus.instr_last_o);
        end
    endtask

    task automatic test_far_jal();
        bit acc, accx;
        do_reset();
        tick(1'b1, op_bit(OP_CJAL), 5'd1, 5'd0, 5'd0, 32'h00100000, 1'b0, acc, accx);
        n_checks++;
        if ({acc, bus.instr_valid_o, bus.instr_o, bus.instr_last_o, bus.instr_err_o}
            !== {1'b1, 1'b1, 32'h00100097, 1'b0, 1'b0}) begin
            n_errors++;
            $display("FAIL far_jal_beat1: got acc=%b v=%b w=%h l=%b e=%b want acc=1 v=1 w=00100097 l=0 e=0",
                     acc, bus.instr_valid_o, bus.instr_o, bus.instr_last_o, bus.instr_err_o);
        end
        tick(1'b1, op_bit(OP_GET_LEN), 5'd1, 5'd2, 5'd0, 32'h0, 1'b1, acc, accx);
        n_checks++;
        if ({acc, bus.instr_valid_o, bus.instr_o, bus.instr_last_o, bus.instr_err_o}
            !== {1'b0, 1'b1, 32'h000080E7, 1'b1, 1'b0}) begin
            n_errors++;
            $display("FAIL far_jal_beat2: got acc=%b v=%b w=%h l=%b e=%b want acc=0 v=1 w=000080e7 l=1 e=0",
                     acc, bus.instr_valid_o, bus.instr_o, bus.instr_last_o, bus.instr_err_o);
        end
        tick(1'b1, op_bit(OP_GET_LEN), 5'd1, 5'd2, 5'd0, 32'h0, 1'b1, acc, accx);
        n_checks++;
        if ({acc, bus.instr_o, bus.instr_last_o} !== {1'b1, 32'hFE3100DB, 1'b1}) begin
            n_errors++;
            $display("FAIL far_jal_next: got acc=%b w=%h l=%b want acc=1 w=fe3100db l=1",
                     acc, bus.instr_o, bus.instr_last_o);
        end
    endtask

    task automatic test_errors();
        logic [31:0] e_op  [0:8];
        logic [4:0]  e_rd  [0:8];
        logic [31:0] e_imm [0:8];
        bit          e_nx  [0:8];
        bit          acc, accx, a;
        e_op = '{op_bit(OP_CINC_IMM), op_bit(OP_CJAL), op_bit(OP_CSET_BOUNDS) | op_bit(OP_CSET_ADDR),
                 op_bit(OP_CJAL), op_bit(OP_CJAL), op_bit(30), 32'h0, op_bit(OP_CSETB_IMM),
                 op_bit(OP_CAUIPCC)};
        e_rd  = '{5'd5, 5'd1, 5'd1, 5'd0, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1};
        e_imm = '{32'h800, 32'd3, 32'h0, 32'h00100000, 32'h00100000, 32'h0, 32'h0, 32'd4096, 32'h00100000};
        e_nx  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int k = 0; k < 9; k++) begin
            do_reset();
            tick(1'b1, e_op[k], e_rd[k], 5'd2, 5'd3, e_imm[k], 1'b0, acc, accx);
            a = e_nx[k] ? accx : acc;
            n_checks++;
            if (e_nx[k] ? ({a, bus_nx.instr_valid_o, bus_nx.instr_o, bus_nx.instr_last_o, bus_nx.instr_err_o}
                           !== {1'b1, 1'b1, 32'h0, 1'b1, 1'b1})
                        : ({a, bus.instr_valid_o, bus.instr_o, bus.instr_last_o, bus.instr_err_o}
                           !== {1'b1, 1'b1, 32'h0, 1'b1, 1'b1})) begin
                n_errors++;
                $display("FAIL error_case_%0d: got acc=%b w=%h/%h e=%b/%b want acc=1 w=0 l=1 e=1",
                         k, a, bus.instr_o, bus_nx.instr_o, bus.instr_err_o, bus_nx.instr_err_o);
            end
        end
    endtask

    task automatic test_backpressure();
        bit acc, accx;
        do_reset();
        tick(1'b1, op_bit(OP_GET_LEN), 5'd1, 5'd2, 5'd0, 32'h0, 1'b0, acc, accx);
        for (int k = 0; k < 3; k++) begin
            tick(1'b1, op_bit(OP_CSET_ADDR), 5'd1, 5'd2, 5'd3, 32'h0, 1'b0, acc, accx);
            n_checks++;
            if ({acc, bus.instr_valid_o, bus.instr_o, bus.instr_last_o, bus.instr_err_o}
                !== {1'b0, 1'b1, 32'hFE3100DB, 1'b1, 1'b0}) begin
                n_errors++;
                $display("FAIL hold_%0d: got acc=%b v=%b w=%h l=%b e=%b want acc=0 v=1 w=fe3100db l=1 e=0",
                         k, acc, bus.instr_valid_o, bus.instr_o, bus.instr_last_o, bus.instr_err_o);
            end
        end
        tick(1'b1, op_bit(OP_CSET_ADDR), 5'd1, 5'd2, 5'd3, 32'h0, 1'b1, acc, accx);
        n_checks++;
        if ({acc, bus.instr_valid_o, bus.instr_o} !== {1'b1, 1'b1, 32'h203100DB}) begin
            n_errors++;
            $display("FAIL hold_release: got acc=%b v=%b w=%h want acc=1 v=1 w=203100db",
                     acc, bus.instr_valid_o, bus.instr_o);
        end
    endtask

    task automatic test_reset_mid_expansion();
        bit acc, accx;
        do_reset();
        tick(1'b1, op_bit(OP_CJAL), 5'd1, 5'd0, 5'd0, 32'h00100000, 1'b0, acc, accx);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.instr_valid_o, bus.req_ready_o} !== {1'b0, 1'b1}) begin
            n_errors++;
            $display("FAIL mid_reset: got v=%b rdy=%b want v=0 rdy=1", bus.instr_valid_o, bus.req_ready_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tick(1'b1, op_bit(OP_CINC_IMM), 5'd5, 5'd6, 5'd0, 32'h7ff, 1'b1, acc, accx);
        n_checks++;
        if ({acc, bus.instr_valid_o, bus.instr_o, bus.instr_last_o} !== {1'b1, 1'b1, 32'h7FF312DB, 1'b1}) begin
            n_errors++;
            $display("FAIL post_reset_encode: got acc=%b v=%b w=%h l=%b want acc=1 v=1 w=7ff312db l=1",
                     acc, bus.instr_valid_o, bus.instr_o, bus.instr_last_o);
        end
        for (int k = 0; k < 2; k++) begin
            tick(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b1, acc, accx);
            n_checks++;
            if (bus.instr_valid_o !== 1'b0) begin
                n_errors++;
                $display("FAIL stale_beat2_%0d: got v=%b w=%h want v=0", k, bus.instr_valid_o, bus.instr_o);
            end
        end
    endtask

    task automatic test_random();
        beat_t       sb[$];
        beat_t       b1, b2;
        bit          v, rdy, acc, accx, exp_rdy, cons;
        int          sel, nb;
        logic [31:0] opv, imm;
        logic [4:0]  rd, rs1, rs2;
        do_reset();
        for (int c = 0; c < 440; c++) begin
            n_checks++;
            if (sb.size() != 0) begin
                if (bus.instr_valid_o !== 1'b1 || bus.instr_o !== sb[0].word ||
                    bus.instr_last_o !== sb[0].last || bus.instr_err_o !== sb[0].err) begin
                    n_errors++;
                    $display("FAIL rand_beat c%0d: got v=%b w=%h l=%b e=%b want v=1 w=%h l=%b e=%b", c,
                             bus.instr_valid_o, bus.instr_o, bus.instr_last_o, bus.instr_err_o,
                             sb[0].word, sb[0].last, sb[0].err);
                end
            end else if (bus.instr_valid_o !== 1'b0) begin
                n_errors++;
                $display("FAIL rand_idle c%0d: got v=%b want 0", c, bus.instr_valid_o);
            end
            sel = $urandom_range(0, 19);
            if (sel == 0)      opv = 32'h0;
            else if (sel == 1) opv = op_bit($urandom_range(0, 31)) | op_bit($urandom_range(0, 31));
            else if (sel == 2) opv = op_bit($urandom_range(30, 31));
            else if (sel <= 6) opv = op_bit(OP_CJAL);
            else               opv = op_bit($urandom_range(0, 29));
            case ($urandom_range(0, 3))
                0:       imm = BND[$urandom_range(0, 14)];
                1:       imm = 32'($urandom_range(0, 8191)) - 32'd4096;
                2:       imm = 32'($urandom_range(0, 32'h3ffffe)) - 32'h200000;
                default: imm = $urandom();
            endcase
            rd  = 5'($urandom_range(0, 31));
            rs1 = 5'($urandom_range(0, 31));
            rs2 = 5'($urandom_range(0, 31));
            v   = (c < 400) ? ($urandom_range(0, 9) < 7) : 1'b0;
            rdy = (c < 400) ? ($urandom_range(0, 3) != 0) : 1'b1;
            exp_rdy = (sb.size() == 0) || (sb.size() == 1 && rdy);
            cons    = (sb.size() != 0) && rdy;
            tick(v, opv, rd, rs1, rs2, imm, rdy, acc, accx);
            n_checks++;
            if (acc !== (v & exp_rdy)) begin
                n_errors++;
                $display("FAIL rand_accept c%0d: got %b want %b", c, acc, v & exp_rdy);
            end
            if (cons) void'(sb.pop_front());
            if (acc) begin
                nb = model(opv, rd, rs1, rs2, imm, 1'b1, b1, b2);
                sb.push_back(b1);
                if (nb == 2) sb.push_back(b2);
            end
        end
        n_checks++;
        if (sb.size() != 0 || bus.instr_valid_o !== 1'b0) begin
            n_errors++;
            $display("FAIL rand_drain: got pending=%0d v=%b want pending=0 v=0", sb.size(), bus.instr_valid_o);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_far_jal();
        test_errors();
        test_backpressure();
        test_reset_mid_expansion();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
